// File: rtl/vga_panel_pkg.sv
// Shared types and constants for the synth front-panel marker plotter.
// Holds the key position table, the plotter state enum and default screen constants.
package vga_panel_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ERASE = 2'd1,
        ST_DRAW  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int         DEF_X_SCREEN  = 320;
    localparam int         DEF_Y_SCREEN  = 240;
    localparam logic [2:0] DEF_BG_COLOUR = 3'b111;
    localparam int         POS_X_W       = 9;
    localparam int         POS_Y_W       = 8;

    // Top-left corner {x, y} of each key's marker; unknown keys map to the origin.
    function automatic logic [POS_X_W+POS_Y_W-1:0] key_pos(input int unsigned k);
        logic [POS_X_W-1:0] x;
        logic [POS_Y_W-1:0] y;
        x = '0;
        y = '0;
        case (k)
            0:       begin x = 9'd66;  y = 8'd124; end
            1:       begin x = 9'd81;  y = 8'd96;  end
            2:       begin x = 9'd99;  y = 8'd124; end
            3:       begin x = 9'd112; y = 8'd96;  end
            4:       begin x = 9'd131; y = 8'd124; end
            5:       begin x = 9'd161; y = 8'd124; end
            6:       begin x = 9'd174; y = 8'd96;  end
            7:       begin x = 9'd192; y = 8'd124; end
            8:       begin x = 9'd209; y = 8'd96;  end
            9:       begin x = 9'd224; y = 8'd124; end
            10:      begin x = 9'd245; y = 8'd96;  end
            11:      begin x = 9'd254; y = 8'd124; end
            default: begin x = '0;     y = '0;     end
        endcase
        return {x, y};
    endfunction

endpackage

// File: rtl/box_sweep.sv
// Row-major col/row counter pair walking one BOX_W x BOX_H box, one pixel per step.
// Wraps to (0,0) after the last pixel so back-to-back phases need no restart.
module box_sweep #(
    parameter int BOX_W = 4,
    parameter int BOX_H = 4,
    parameter int CW    = (BOX_W > 1) ? $clog2(BOX_W) : 1,
    parameter int RW    = (BOX_H > 1) ? $clog2(BOX_H) : 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  logic          i_step,
    output logic [CW-1:0] o_col,
    output logic [RW-1:0] o_row,
    output logic          o_last
);

    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic          w_col_end;
    logic          w_row_end;

    assign w_col_end = (r_col == CW'(BOX_W - 1));
    assign w_row_end = (r_row == RW'(BOX_H - 1));
    assign o_last    = w_col_end && w_row_end;
    assign o_col     = r_col;
    assign o_row     = r_row;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_start) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_step) begin
            if (w_col_end) begin
                r_col <= '0;
                r_row <= w_row_end ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_marker_plotter.sv
// Erases the previous key marker and draws a new filled box as a pixel-write stream,
// holding one pending request (latest wins) while a sweep is in progress.
module vga_marker_plotter
    import vga_panel_pkg::*;
#(
    parameter int               BOX_W     = 4,
    parameter int               BOX_H     = 4,
    parameter int               NUM_KEYS  = 12,
    parameter int               KEY_W     = 4,
    parameter int               X_W       = 9,
    parameter int               Y_W       = 8,
    parameter int               COL_W     = 3,
    parameter int               X_SCREEN  = DEF_X_SCREEN,
    parameter int               Y_SCREEN  = DEF_Y_SCREEN,
    parameter logic [COL_W-1:0] BG_COLOUR = COL_W'(DEF_BG_COLOUR),
    parameter int               KEY11_X   = 254
) (
    input  logic                     iClock,
    input  logic                     iResetn,
    input  logic                     iReq,
    input  logic [KEY_W-1:0]         iKey,
    input  logic [COL_W-1:0]         iColour,
    input  logic                     iClear,
    output logic [X_W-1:0]           oX,
    output logic [Y_W-1:0]           oY,
    output logic [COL_W-1:0]         oColour,
    output logic                     oPlot,
    output logic                     oBusy,
    output logic                     oDone,
    output logic                     oErr,
    output state_t                   oDbgState,
    output logic [KEY_W+COL_W:0]     oDbgMarker
);

    localparam int CW = (BOX_W > 1) ? $clog2(BOX_W) : 1;
    localparam int RW = (BOX_H > 1) ? $clog2(BOX_H) : 1;

    state_t             r_state;
    logic               r_act_clear;
    logic [KEY_W-1:0]   r_act_key;
    logic [COL_W-1:0]   r_act_col;
    logic               r_pend_valid;
    logic               r_pend_clear;
    logic [KEY_W-1:0]   r_pend_key;
    logic [COL_W-1:0]   r_pend_col;
    logic               r_mk_valid;
    logic [KEY_W-1:0]   r_mk_key;
    logic [COL_W-1:0]   r_mk_col;

    logic               w_key_ok, w_bad, w_new, w_have, w_sweeping, w_last, w_on_screen;
    logic               w_src_clear;
    logic [KEY_W-1:0]   w_src_key, w_pix_key;
    logic [COL_W-1:0]   w_src_col, w_pix_col;
    logic [CW-1:0]      w_col;
    logic [RW-1:0]      w_row;
    logic [POS_X_W+POS_Y_W-1:0] w_pos;
    logic [X_W-1:0]     w_kx;
    logic [Y_W-1:0]     w_ky;
    logic [X_W:0]       w_x_sum;
    logic [Y_W:0]       w_y_sum;

    // A bad key drops the whole input cycle, including any simultaneous clear.
    assign w_key_ok    = (32'(iKey) < NUM_KEYS);
    assign w_bad       = iReq && !w_key_ok;
    assign w_new       = (iReq && w_key_ok) || (!iReq && iClear);
    assign w_have      = w_new || r_pend_valid;
    assign w_src_clear = w_new ? !iReq   : r_pend_clear;
    assign w_src_key   = w_new ? iKey    : r_pend_key;
    assign w_src_col   = w_new ? iColour : r_pend_col;

    assign w_sweeping  = (r_state == ST_ERASE) || (r_state == ST_DRAW);
    assign w_pix_key   = (r_state == ST_ERASE) ? r_mk_key : r_act_key;
    assign w_pix_col   = (r_state == ST_ERASE) ? BG_COLOUR : r_act_col;
    assign w_pos       = key_pos(32'(w_pix_key));
    assign w_kx        = (32'(w_pix_key) == 11) ? X_W'(KEY11_X) : X_W'(w_pos[POS_X_W+POS_Y_W-1:POS_Y_W]);
    assign w_ky        = Y_W'(w_pos[POS_Y_W-1:0]);
    assign w_x_sum     = {1'b0, w_kx} + (X_W+1)'(w_col);
    assign w_y_sum     = {1'b0, w_ky} + (Y_W+1)'(w_row);
    assign w_on_screen = (32'(w_x_sum) < X_SCREEN) && (32'(w_y_sum) < Y_SCREEN);

    assign oDbgState   = r_state;
    assign oDbgMarker  = {r_mk_valid, r_mk_key, r_mk_col};

    box_sweep #(.BOX_W(BOX_W), .BOX_H(BOX_H), .CW(CW), .RW(RW)) u_sweep (
        .i_clk   (iClock),
        .i_rst_n (iResetn),
        .i_start (!w_sweeping),
        .i_step  (w_sweeping),
        .o_col   (w_col),
        .o_row   (w_row),
        .o_last  (w_last)
    );

    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            r_state      <= ST_IDLE;
            r_act_clear  <= 1'b0;
            r_act_key    <= '0;
            r_act_col    <= '0;
            r_pend_valid <= 1'b0;
            r_pend_clear <= 1'b0;
            r_pend_key   <= '0;
            r_pend_col   <= '0;
            r_mk_valid   <= 1'b0;
            r_mk_key     <= '0;
            r_mk_col     <= '0;
            oX           <= '0;
            oY           <= '0;
            oColour      <= '0;
            oPlot        <= 1'b0;
            oBusy        <= 1'b0;
            oDone        <= 1'b0;
            oErr         <= 1'b0;
        end else begin
            oDone <= 1'b0;
            oErr  <= w_bad;
            oPlot <= 1'b0;
            oBusy <= (r_state != ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (w_new) begin
                        r_act_clear <= w_src_clear;
                        r_act_key   <= w_src_key;
                        r_act_col   <= w_src_col;
                        if (r_mk_valid)       r_state <= ST_ERASE;
                        else if (w_src_clear) oDone   <= 1'b1;
                        else                  r_state <= ST_DRAW;
                    end
                end
                ST_ERASE, ST_DRAW: begin
                    oX      <= w_x_sum[X_W-1:0];
                    oY      <= w_y_sum[Y_W-1:0];
                    oColour <= w_pix_col;
                    oPlot   <= w_on_screen;
                    if (w_new) begin
                        r_pend_valid <= 1'b1;
                        r_pend_clear <= w_src_clear;
                        r_pend_key   <= w_src_key;
                        r_pend_col   <= w_src_col;
                    end
                    if (w_last) begin
                        if (r_state == ST_DRAW) begin
                            r_mk_valid <= 1'b1;
                            r_mk_key   <= r_act_key;
                            r_mk_col   <= r_act_col;
                            r_state    <= ST_DONE;
                        end else if (r_act_clear) begin
                            r_mk_valid <= 1'b0;
                            r_state    <= ST_DONE;
                        end else begin
                            r_state    <= ST_DRAW;
                        end
                    end
                end
                ST_DONE: begin
                    oDone        <= 1'b1;
                    r_pend_valid <= 1'b0;
                    // Chain straight into the next request so no IDLE cycle appears.
                    if (w_have) begin
                        r_act_clear <= w_src_clear;
                        r_act_key   <= w_src_key;
                        r_act_col   <= w_src_col;
                        if (r_mk_valid)       r_state <= ST_ERASE;
                        else if (w_src_clear) r_state <= ST_DONE;
                        else                  r_state <= ST_DRAW;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_marker_plotter.sv
// Bench for vga_marker_plotter: a 4x4 instance plus two 8-wide instances (normal and
// right-edge key 11) checked cycle by cycle against a pixel-list model of the panel.
module tb_vga_marker_plotter;
  import vga_panel_pkg::*;

  localparam int BW = 4;
  localparam int BH = 4;
  localparam int BW_WIDE = 8;
  localparam logic [21:0] DONE_W = 22'h200000;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic req0 = 1'b0, clr0 = 1'b0;
  logic [3:0] key0 = '0;
  logic [2:0] col0 = '0;
  logic [8:0] x0;
  logic [7:0] y0;
  logic [2:0] c0;
  logic p0, busy0, done0, err0;
  state_t st0;
  logic [7:0] mk0;

  logic req1 = 1'b0;
  logic [3:0] key1 = '0;
  logic [2:0] col1 = '0;
  logic [8:0] x1, x2;
  logic [7:0] y1, y2;
  logic [2:0] c1, c2;
  logic p1, p2, busy1, busy2, done1, done2, err1, err2;
  state_t st1, st2;
  logic [7:0] mk1, mk2;

  vga_marker_plotter #(.BOX_W(BW), .BOX_H(BH)) dut0 (
    .iClock(clk), .iResetn(rst_n), .iReq(req0), .iKey(key0), .iColour(col0), .iClear(clr0),
    .oX(x0), .oY(y0), .oColour(c0), .oPlot(p0), .oBusy(busy0), .oDone(done0), .oErr(err0),
    .oDbgState(st0), .oDbgMarker(mk0));

  vga_marker_plotter #(.BOX_W(BW_WIDE), .BOX_H(BH)) dut1 (
    .iClock(clk), .iResetn(rst_n), .iReq(req1), .iKey(key1), .iColour(col1), .iClear(1'b0),
    .oX(x1), .oY(y1), .oColour(c1), .oPlot(p1), .oBusy(busy1), .oDone(done1), .oErr(err1),
    .oDbgState(st1), .oDbgMarker(mk1));

  vga_marker_plotter #(.BOX_W(BW_WIDE), .BOX_H(BH), .KEY11_X(316)) dut2 (
    .iClock(clk), .iResetn(rst_n), .iReq(req1), .iKey(key1), .iColour(col1), .iClear(1'b0),
    .oX(x2), .oY(y2), .oColour(c2), .oPlot(p2), .oBusy(busy2), .oDone(done2), .oErr(err2),
    .oDbgState(st2), .oDbgMarker(mk2));

  // ---------------- reference model ----------------
  int kx_tab[12] = '{66, 81, 99, 112, 131, 161, 174, 192, 209, 224, 245, 254};
  logic [21:0] exp_q[$];
  logic [21:0] exp1_q[$];
  logic [21:0] exp2_q[$];
  logic m_valid = 1'b0;
  int m_key = 0;
  logic [2:0] m_col = '0;
  int n_cmp = 0;
  int n_err = 0;

  function automatic int ref_ky(int k);
    return (k inside {0, 2, 4, 5, 7, 9, 11}) ? 124 : 96;
  endfunction

  function automatic void push_box(int sel, int kx, int ky, int bw, logic [2:0] c);
    for (int r = 0; r < BH; r++) begin
      for (int cc = 0; cc < bw; cc++) begin
        int x;
        int y;
        logic [21:0] w;
        x = kx + cc;
        y = ky + r;
        w = {1'b0, logic'((x < 320) && (y < 240)), 9'(x), 8'(y), c};
        if (sel == 0) exp_q.push_back(w);
        else if (sel == 1) exp1_q.push_back(w);
        else exp2_q.push_back(w);
      end
    end
  endfunction

  function automatic void model_op0(logic is_clear, int k, logic [2:0] c);
    if (m_valid) push_box(0, kx_tab[m_key], ref_ky(m_key), BW, 3'b111);
    if (is_clear) begin
      m_valid = 1'b0;
    end else begin
      push_box(0, kx_tab[k], ref_ky(k), BW, c);
      m_valid = 1'b1;
      m_key = k;
      m_col = c;
    end
    exp_q.push_back(DONE_W);
  endfunction

  // ---------------- drivers ----------------
  task automatic drive_req0(int k, logic [2:0] c);
    @(negedge clk);
    req0 = 1'b1; key0 = 4'(k); col0 = c;
    @(posedge clk); #1;
    req0 = 1'b0;
  endtask

  task automatic drive_clr0();
    @(negedge clk);
    clr0 = 1'b1;
    @(posedge clk); #1;
    clr0 = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({x0, y0, c0, p0, busy0, done0, err0} !== '0) begin
      n_err++; $display("FAIL reset_out0: got %h want 0", {x0, y0, c0, p0, busy0, done0, err0});
    end
    n_cmp++;
    if (st0 !== ST_IDLE || mk0 !== 8'h00) begin
      n_err++; $display("FAIL reset_state0: got st=%0d mk=%h want st=0 mk=00", st0, mk0);
    end
    n_cmp++;
    if ({x1, y1, c1, p1, busy1, done1, err1, x2, y2, c2, p2, busy2, done2, err2} !== '0) begin
      n_err++; $display("FAIL reset_wide: outputs of wide instances not all zero");
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_first_draw();
    model_op0(1'b0, 0, 3'b001);
    drive_req0(0, 3'b001);
    while (exp_q.size() > 0) begin
      logic [21:0] e;
      e = exp_q.pop_front();
      @(posedge clk); #1;
      n_cmp++;
      if (e[21]) begin
        if ({done0, p0, busy0} !== 3'b101) begin
          n_err++; $display("FAIL first_draw_done: got done=%b plot=%b busy=%b want 1 0 1", done0, p0, busy0);
        end
      end else if ({done0, p0, x0, y0, c0, busy0} !== {e, 1'b1}) begin
        n_err++; $display("FAIL first_draw_pix: got %h want %h", {done0, p0, x0, y0, c0, busy0}, {e, 1'b1});
      end
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({busy0, done0} !== 2'b00) begin
      n_err++; $display("FAIL first_draw_idle: got busy=%b done=%b want 0 0", busy0, done0);
    end
  endtask

  task automatic test_erase_draw();
    model_op0(1'b0, 1, 3'b100);
    drive_req0(1, 3'b100);
    while (exp_q.size() > 0) begin
      logic [21:0] e;
      e = exp_q.pop_front();
      @(posedge clk); #1;
      n_cmp++;
      if (e[21]) begin
        if ({done0, p0, busy0} !== 3'b101) begin
          n_err++; $display("FAIL erase_draw_done: got done=%b plot=%b busy=%b want 1 0 1", done0, p0, busy0);
        end
      end else if ({done0, p0, x0, y0, c0, busy0} !== {e, 1'b1}) begin
        n_err++; $display("FAIL erase_draw_pix: got %h want %h", {done0, p0, x0, y0, c0, busy0}, {e, 1'b1});
      end
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({busy0, done0} !== 2'b00) begin
      n_err++; $display("FAIL erase_draw_idle: got busy=%b done=%b want 0 0", busy0, done0);
    end
  endtask

  task automatic test_bad_key();
    int k;
    k = $urandom_range(12, 15);
    drive_req0(k, 3'($urandom_range(0, 7)));
    n_cmp++;
    if ({err0, busy0, p0} !== 3'b100) begin
      n_err++; $display("FAIL bad_key_err: got err=%b busy=%b plot=%b want 1 0 0", err0, busy0, p0);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({err0, busy0, p0, done0} !== 4'b0000) begin
        n_err++; $display("FAIL bad_key_quiet: got err=%b busy=%b plot=%b done=%b want 0", err0, busy0, p0, done0);
      end
    end
    n_cmp++;
    if (mk0 !== {m_valid, 4'(m_key), m_col}) begin
      n_err++; $display("FAIL bad_key_marker: got %h want %h", mk0, {m_valid, 4'(m_key), m_col});
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [2:0] ca, cb, cc;
    ca = 3'($urandom_range(0, 7));
    cb = 3'($urandom_range(0, 7));
    cc = 3'($urandom_range(0, 7));
    model_op0(1'b0, 5, ca);
    model_op0(1'b0, 3, cc);
    n = exp_q.size();
    drive_req0(5, ca);
    for (int i = 0; i < n; i++) begin
      logic [21:0] e;
      e = exp_q.pop_front();
      @(posedge clk); #1;
      n_cmp++;
      if (e[21]) begin
        if ({done0, p0, busy0} !== 3'b101) begin
          n_err++; $display("FAIL b2b_done[%0d]: got done=%b plot=%b busy=%b want 1 0 1", i, done0, p0, busy0);
        end
      end else if ({done0, p0, x0, y0, c0, busy0} !== {e, 1'b1}) begin
        n_err++; $display("FAIL b2b_pix[%0d]: got %h want %h", i, {done0, p0, x0, y0, c0, busy0}, {e, 1'b1});
      end
      if (i == 4) begin req0 = 1'b1; key0 = 4'd2; col0 = cb; end
      else if (i == 8) begin req0 = 1'b1; key0 = 4'd3; col0 = cc; end
      else req0 = 1'b0;
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({busy0, done0, p0} !== 3'b000) begin
      n_err++; $display("FAIL b2b_idle: got busy=%b done=%b plot=%b want 0 0 0", busy0, done0, p0);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      logic is_clr;
      int k;
      logic [2:0] c;
      is_clr = m_valid && ($urandom_range(0, 3) == 0);
      k = $urandom_range(0, 11);
      c = 3'($urandom_range(0, 7));
      model_op0(is_clr, k, c);
      if (is_clr) drive_clr0();
      else drive_req0(k, c);
      while (exp_q.size() > 0) begin
        logic [21:0] e;
        e = exp_q.pop_front();
        @(posedge clk); #1;
        n_cmp++;
        if (e[21]) begin
          if ({done0, p0, busy0} !== 3'b101) begin
            n_err++; $display("FAIL random_done[%0d]: got done=%b plot=%b busy=%b want 1 0 1", t, done0, p0, busy0);
          end
        end else if ({done0, p0, x0, y0, c0, busy0} !== {e, 1'b1}) begin
          n_err++; $display("FAIL random_pix[%0d]: got %h want %h", t, {done0, p0, x0, y0, c0, busy0}, {e, 1'b1});
        end
      end
      @(posedge clk); #1;
      n_cmp++;
      if ({busy0, done0} !== 2'b00) begin
        n_err++; $display("FAIL random_idle[%0d]: got busy=%b done=%b want 0 0", t, busy0, done0);
      end
    end
  endtask

  task automatic test_wide_clip();
    logic [2:0] c;
    c = 3'($urandom_range(0, 7));
    push_box(1, 254, 124, BW_WIDE, c);
    exp1_q.push_back(DONE_W);
    push_box(2, 316, 124, BW_WIDE, c);
    exp2_q.push_back(DONE_W);
    @(negedge clk);
    req1 = 1'b1; key1 = 4'd11; col1 = c;
    @(posedge clk); #1;
    req1 = 1'b0;
    while (exp1_q.size() > 0) begin
      logic [21:0] e1, e2;
      e1 = exp1_q.pop_front();
      e2 = exp2_q.pop_front();
      @(posedge clk); #1;
      n_cmp++;
      if (e1[21]) begin
        if ({done1, p1, done2, p2} !== 4'b1010) begin
          n_err++; $display("FAIL wide_done: got %b%b %b%b want 10 10", done1, p1, done2, p2);
        end
      end else if ({done1, p1, x1, y1, c1} !== e1 || {done2, p2, x2, y2, c2} !== e2) begin
        n_err++; $display("FAIL wide_pix: got %h/%h want %h/%h",
                          {done1, p1, x1, y1, c1}, {done2, p2, x2, y2, c2}, e1, e2);
      end
    end
  endtask

  task automatic test_reset_mid();
    drive_req0($urandom_range(0, 11), 3'($urandom_range(0, 7)));
    repeat (6) @(posedge clk);
    #1;
    n_cmp++;
    if (busy0 !== 1'b1) begin
      n_err++; $display("FAIL reset_mid_busy: got busy=%b want 1", busy0);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({x0, y0, c0, p0, busy0, done0, err0} !== '0) begin
      n_err++; $display("FAIL reset_mid_out: got %h want 0", {x0, y0, c0, p0, busy0, done0, err0});
    end
    m_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive_clr0();
    n_cmp++;
    if ({done0, busy0, p0} !== 3'b100) begin
      n_err++; $display("FAIL clear_invalid_done: got done=%b busy=%b plot=%b want 1 0 0", done0, busy0, p0);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({done0, busy0, p0} !== 3'b000) begin
        n_err++; $display("FAIL clear_invalid_quiet: got done=%b busy=%b plot=%b want 0 0 0", done0, busy0, p0);
      end
    end
    n_cmp++;
    if (mk0[7] !== 1'b0) begin
      n_err++; $display("FAIL clear_invalid_marker: got valid=%b want 0", mk0[7]);
    end
  endtask

  initial begin
    test_reset();
    test_first_draw();
    test_erase_draw();
    test_bad_key();
    test_back_to_back();
    test_random();
    test_wide_clip();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
